// File: rtl/ext_pkg.sv
// Shared constants and the extension function for the immediate extender.
// The function works on MAX_W-wide vectors, and the caller passes in the real widths.
package ext_pkg;

    localparam int MODE_W = 3;
    localparam int MAX_W  = 64;

    localparam logic [MODE_W-1:0] EXT_ZERO   = 3'd0;
    localparam logic [MODE_W-1:0] EXT_SIGN   = 3'd1;
    localparam logic [MODE_W-1:0] EXT_HIGH   = 3'd2;
    localparam logic [MODE_W-1:0] EXT_BRANCH = 3'd3;
    localparam logic [MODE_W-1:0] EXT_JUMP   = 3'd4;

    function automatic logic [MAX_W-1:0] low_mask(input int w);
        return ~({MAX_W{1'b1}} << w);
    endfunction

    // Returns {err, data}. Only the low data_w bits of data are meaningful.
    function automatic logic [MAX_W:0] ext_compute(
        input logic [MODE_W-1:0] mode,
        input logic [MAX_W-1:0]  imm,
        input logic [MAX_W-1:0]  jtgt,
        input logic [MAX_W-1:0]  pc,
        input int                data_w,
        input int                imm_w,
        input int                jmp_w,
        input logic              branch_en
    );
        logic [MAX_W-1:0] imm_z;
        logic [MAX_W-1:0] sext;
        logic [MAX_W-1:0] data;
        logic             err;
        imm_z = imm & low_mask(imm_w);
        sext  = imm_z;
        if (((imm_z >> (imm_w - 1)) & MAX_W'(1)) != '0) begin
            sext = imm_z | ({MAX_W{1'b1}} << imm_w);
        end
        data = imm_z;
        err  = 1'b0;
        case (mode)
            EXT_ZERO: data = imm_z;
            EXT_SIGN: data = sext;
            EXT_HIGH: data = imm_z << (data_w - imm_w);
            EXT_BRANCH: begin
                if (branch_en) data = sext << 2;
                else           err  = 1'b1;
            end
            EXT_JUMP: begin
                if (branch_en) data = (pc & ~low_mask(jmp_w + 2)) | ((jtgt & low_mask(jmp_w)) << 2);
                else           err  = 1'b1;
            end
            default: err = 1'b1;
        endcase
        return {err, data & low_mask(data_w)};
    endfunction

endpackage

// File: rtl/ext_fifo2.sv
// Generic two-entry registered FIFO. The head always lives in entry 0.
// Flush empties it and takes priority over push and pop, and reset also zeroes the entries.
module ext_fifo2
    import ext_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    always_comb begin
        push_ok = push && (count_q != 2'd2);
        pop_ok  = pop && (count_q != 2'd0);
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) mem0_d = push_data;
                    else                 mem1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    mem0_d  = mem1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop leaves the count unchanged.
                    if (count_q == 2'd1) begin
                        mem0_d = push_data;
                    end else begin
                        mem0_d = mem1_q;
                        mem1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem0_q;
    assign count     = count_q;

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate/jump-target extender that feeds a 2-entry output buffer.
// Define EXT_BRANCH_EN to enable the BRANCH and JUMP modes; otherwise they are illegal.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [JMP_W-1:0]  in_jtgt,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

`ifdef EXT_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    logic [MAX_W:0]  ext_full;
    logic [DATA_W:0] push_data;
    logic [DATA_W:0] head_data;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    always_comb begin
        ext_full  = ext_compute(in_mode, MAX_W'(in_imm), MAX_W'(in_jtgt), MAX_W'(in_pc),
                                DATA_W, IMM_W, JMP_W, BRANCH_EN);
        push_data = {ext_full[MAX_W], ext_full[DATA_W-1:0]};
    end

    // The upper working bits of the extension result are always zero.
    if (DATA_W < MAX_W) begin : g_unused_hi
        logic unused_ext_hi;
        assign unused_ext_hi = ^ext_full[MAX_W-1:DATA_W];
    end

    // in_ready is derived from registered state and rst only, never from out_ready.
    assign in_ready  = (count != 2'd2) && !rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head_data[DATA_W-1:0];
    assign out_err   = head_data[DATA_W];

    ext_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe with directed cases followed by a randomized run.
// A queue holds the expected results in order.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_imm;
    logic [25:0] in_jtgt;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

`ifdef EXT_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(32), .IMM_W(16), .JMP_W(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_jtgt   (in_jtgt),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    function automatic logic [32:0] ref_ext(input logic [2:0] m, input logic [15:0] imm,
                                            input logic [25:0] jt, input logic [31:0] pc);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (m)
            3'd0: return {1'b0, 16'h0000, imm};
            3'd1: return {1'b0, s};
            3'd2: return {1'b0, imm, 16'h0000};
            3'd3: if (BR_EN) return {1'b0, s[29:0], 2'b00};
            3'd4: if (BR_EN) return {1'b0, pc[31:28], jt, 2'b00};
            default: ;
        endcase
        return {1'b1, 16'h0000, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle. Check the outputs against the model, then advance the model across the edge.
    task automatic step(input logic v, input logic [2:0] m, input logic [15:0] imm,
                        input logic [25:0] jt, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic r);
        logic acc;
        logic popd;
        in_valid  = v;
        in_mode   = m;
        in_imm    = imm;
        in_jtgt   = jt;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2 && !r));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0][31:0]));
            chk("out_err", 64'(out_err), 64'(exp_q[0][32]));
        end
        acc  = v && (exp_q.size() < 2) && !r;
        popd = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if (r || fl) begin
            exp_q.delete();
        end else begin
            if (popd) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_ext(m, imm, jt, pc));
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 16'h0, 26'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 3'd0;
        in_imm = '0; in_jtgt = '0; in_pc = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_data", 64'(out_data), 64'(0));
        chk("reset_err", 64'(out_err), 64'(0));

        // Immediate modes with out_ready held high. Each result shows one cycle after acceptance.
        step(1'b1, 3'd1, 16'h8000, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("sign_lit", 64'({out_valid, out_err, out_data}), 64'({2'b10, 32'hFFFF8000}));
        step(1'b1, 3'd0, 16'h8000, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("zero_lit", 64'({out_valid, out_err, out_data}), 64'({2'b10, 32'h00008000}));
        step(1'b1, 3'd2, 16'h1234, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("high_lit", 64'({out_valid, out_err, out_data}), 64'({2'b10, 32'h12340000}));
        idle(1'b1);
        chk("drained", 64'(out_valid), 64'(0));

`ifdef EXT_BRANCH_EN
        step(1'b1, 3'd3, 16'hFFFF, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("branch_lit", 64'({out_err, out_data}), 64'({1'b0, 32'hFFFFFFFC}));
        step(1'b1, 3'd4, 16'h0, 26'h0000010, 32'h40001234, 1'b1, 1'b0, 1'b0);
        chk("jump_lit", 64'({out_err, out_data}), 64'({1'b0, 32'h40000040}));
`else
        step(1'b1, 3'd3, 16'hABCD, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("mode3_illegal", 64'({out_err, out_data}), 64'({1'b1, 32'h0000ABCD}));
        step(1'b1, 3'd7, 16'hABCD, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("mode7_illegal", 64'({out_err, out_data}), 64'({1'b1, 32'h0000ABCD}));
`endif
        idle(1'b1);

        // Backpressure: A and B fill the buffer and C waits until a slot opens.
        step(1'b1, 3'd0, 16'h00A0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 16'h00B0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 64'(in_ready), 64'(0));
        step(1'b1, 3'd0, 16'h00C0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 16'h00C0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 16'h00C0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("c_after_b", 64'({out_valid, out_data}), 64'({1'b1, 32'h000000C0}));
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a push offered in the same cycle.
        step(1'b1, 3'd1, 16'h1111, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h2222, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h3333, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_ready", 64'(in_ready), 64'(1));
        idle(1'b1);

        // Reset mid-stream with two entries held.
        step(1'b1, 3'd2, 16'h4444, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 16'h5555, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 16'h6666, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_data", 64'(out_data), 64'(0));
        chk("rst_mid_err", 64'(out_err), 64'(0));
        step(1'b1, 3'd0, 16'h7777, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("resume", 64'({out_valid, out_data}), 64'({1'b1, 32'h00007777}));

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 26'($urandom), 32'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate extender for the pipelined CPU datapath, sitting between the decode stage and the ALU/branch-target operand muxes. It extends an instruction immediate or jump target to the datapath width according to a mode field and registers the result. A two-entry output buffer with valid/ready handshakes and a synchronous flush for branch mispredicts lets the stage absorb one cycle of downstream stall without losing data.

## Interface
- DATA_W, 32: datapath width; must be ≥ IMM_W+2 and ≥ JMP_W+3.
- IMM_W, 16: immediate field width.
- JMP_W, 26: jump-target field width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; **synchronous, active-high**.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input request valid.
- in_ready  out  1  block can accept the request this cycle.
- in_mode  in  3  extension mode; see Operation.
- in_imm  in  IMM_W  immediate field.
- in_jtgt  in  JMP_W  jump-target field.
- in_pc  in  DATA_W  PC of the instruction (PC+4 for jump composition).
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  extended value.
- out_err  out  1  head entry came from an illegal mode.

## Operation
- Modes:
  - 0 ZERO: {0, imm}.
  - 1 SIGN: imm replicated from bit IMM_W-1.
  - 2 HIGH: imm in the top IMM_W bits, low bits zero.
  - 3 BRANCH: sign-extended imm shifted left by 2.
  - 4 JUMP: {in_pc[DATA_W-1:JMP_W+2], jtgt, 2'b00}.
  - 5–7 are illegal: out_data is the ZERO result and out_err is 1.
- The input is accepted when in_valid && in_ready. The result is computed combinationally and written together with err into the 2-entry FIFO.
- in_ready = (count < 2) && !rst. It depends only on registered state, with no combinational path from out_ready.
- The head entry is popped when out_valid && out_ready. Push and pop may occur in the same cycle when count is 1, leaving count unchanged.
- out_valid = (count != 0). out_data and out_err always show the head entry. When the FIFO is empty they hold their last values, which are not guaranteed.
- flush takes priority over push and pop: count becomes 0 and a push offered in the same cycle is dropped. out_valid is 0 from the next cycle.
- Ordering is strictly FIFO. No entry may be duplicated or dropped except by flush or reset.

## Timing
- Latency is 1 cycle from acceptance to out_valid when the FIFO is empty and out_ready is held high.
- Throughput is 1 result per cycle under a sustained out_ready.
- With out_ready low, two requests are accepted and in_ready drops in the cycle after the second acceptance.
- Reset is synchronous. It clears count and both entries to 0, so out_valid=0, out_data=0, out_err=0 in the cycle after rst is sampled high.
- in_ready is 0 while rst is high. Reset asserted mid-stream discards all entries, identically to flush.

## Configuration
- EXT_BRANCH_EN defined: modes 3 (BRANCH) and 4 (JUMP) are legal and behave as above.
- EXT_BRANCH_EN undefined: modes 3 and 4 are treated as illegal (ZERO result, out_err=1). The in_jtgt and in_pc ports remain present but unused.

## Structure
- Package ext_pkg holds:
  - Mode localparams EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_BRANCH, EXT_JUMP.
  - The mode width constant (3).
  - A parametrised extension function returning {err, data}.
- Sub-module ext_fifo2 is a generic 2-entry registered FIFO (width param) with push/pop/flush, count, and synchronous reset. ext_pipe instantiates it with width DATA_W+1.

## Test plan
All cases use defaults DATA_W=32, IMM_W=16, JMP_W=26.
- Immediate modes, out_ready=1:
  - SIGN imm 0x8000 → 0xFFFF8000, err=0.
  - ZERO imm 0x8000 → 0x00008000.
  - HIGH imm 0x1234 → 0x12340000.
  - Each result appears exactly 1 cycle after acceptance.
- With EXT_BRANCH_EN:
  - BRANCH imm 0xFFFF → 0xFFFFFFFC.
  - JUMP jtgt 0x0000010, pc 0x40001234 → 0x40000040.
- Without EXT_BRANCH_EN, mode 3 and mode 7 with imm 0xABCD → out_data 0x0000ABCD, out_err=1.
- Backpressure: hold out_ready=0 and offer A, B, C back-to-back.
  - A and B are accepted, then in_ready=0 and C is held.
  - Raise out_ready: the outputs are A, B, C in order, with no gaps after C is accepted.
- Flush with count=2 and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the offered item never appears.
- Assert rst for 1 cycle mid-stream with 2 entries → out_valid=0, out_data=0, out_err=0 next cycle; normal operation resumes the following cycle.
